// File: rtl/reg_read_stage.sv
// Operand-read stage: register array, busy scoreboard, one-entry output buffer.
// Optional macro REG_READ_WB_BYPASS_EN forwards same-cycle writeback data.
module reg_read_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       out_valid_q, out_valid_d;
  logic [XLEN-1:0]            out_a_q, out_a_d;
  logic [XLEN-1:0]            out_b_q, out_b_d;
  logic [AW-1:0]              out_rd_q, out_rd_d;
  logic                       out_rd_we_q, out_rd_we_d;

  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] busy_eff;
  logic             hz;
  logic             issue;
  logic [XLEN-1:0]  op_a, op_b;

  always_comb begin
    wb_hit = '0;
    if (wb_en && wb_addr != '0)
      wb_hit[wb_addr] = 1'b1;
  end

`ifdef REG_READ_WB_BYPASS_EN
  assign busy_eff = busy_q & ~wb_hit;
`else
  assign busy_eff = busy_q;
`endif

  always_comb begin
    hz = 1'b0;
    if (in_rs1 != '0 && busy_eff[in_rs1])
      hz = 1'b1;
    if (in_rs2 != '0 && busy_eff[in_rs2])
      hz = 1'b1;
    if (in_rd_we && in_rd != '0 && busy_eff[in_rd])
      hz = 1'b1;
  end

  assign in_ready = (!out_valid_q || out_ready) && !hz;
  assign issue    = in_valid && in_ready;

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (in_rs1 != '0) begin
      op_a = regs_q[in_rs1];
`ifdef REG_READ_WB_BYPASS_EN
      if (wb_hit[in_rs1])
        op_a = wb_data;
`endif
    end
    if (in_rs2 != '0) begin
      op_b = regs_q[in_rs2];
`ifdef REG_READ_WB_BYPASS_EN
      if (wb_hit[in_rs2])
        op_b = wb_data;
`endif
    end
  end

  // Issue set is applied after the writeback clear so it wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q & ~wb_hit;
    if (wb_en && wb_addr != '0)
      regs_d[wb_addr] = wb_data;
    if (issue && in_rd_we && in_rd != '0)
      busy_d[in_rd] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    unique case (1'b1)
      issue: begin
        out_valid_d = 1'b1;
        out_a_d     = op_a;
        out_b_d     = op_b;
        out_rd_d    = in_rd;
        out_rd_we_d = in_rd_we;
      end
      (!issue && out_ready): begin
        out_valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      regs_q      <= '0;
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios plus random traffic
// against an array/scoreboard reference model.
module tb_reg_read_stage;

`ifdef REG_READ_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid, in_ready;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_rd;
  logic        out_rd_we;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_rd_we  (in_rd_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd),
    .out_rd_we (out_rd_we),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [16];
  bit          m_busy [16];
  bit          m_ov, m_owe;
  logic [31:0] m_oa, m_ob;
  logic [3:0]  m_ord;
  bit          obs_rdy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 0;
    end
    m_ov = 0; m_owe = 0; m_oa = 0; m_ob = 0; m_ord = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_ov"},  {31'b0, out_valid}, {31'b0, m_ov});
    chk({tag, "_a"},   out_a, m_oa);
    chk({tag, "_b"},   out_b, m_ob);
    chk({tag, "_rd"},  {28'b0, out_rd}, {28'b0, m_ord});
    chk({tag, "_we"},  {31'b0, out_rd_we}, {31'b0, m_owe});
  endtask

  function automatic bit busy_now(input logic [3:0] r, input bit wbc,
                                  input logic [3:0] wa);
    if (r == 0) return 0;
    if (BYP && wbc && wa == r) return 0;
    return m_busy[r];
  endfunction

  function automatic logic [31:0] val_now(input logic [3:0] r, input bit wbc,
                                          input logic [3:0] wa,
                                          input logic [31:0] wd);
    if (r == 0) return 0;
    if (BYP && wbc && wa == r) return wd;
    return m_regs[r];
  endfunction

  // One clock: drive after negedge, check in_ready, advance model, check outputs.
  task automatic step(input bit iv, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [3:0] d, input bit we, input bit ordy,
                      input bit wbe, input logic [3:0] wa,
                      input logic [31:0] wd, input string tag);
    bit wbc, hz, rdy, iss;
    logic [31:0] va, vb;
    @(negedge clk);
    in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = d; in_rd_we = we;
    out_ready = ordy; wb_en = wbe; wb_addr = wa; wb_data = wd;
    #1;
    wbc = wbe && wa != 0;
    hz  = busy_now(r1, wbc, wa) || busy_now(r2, wbc, wa)
       || (we && busy_now(d, wbc, wa));
    rdy = (!m_ov || ordy) && !hz;
    iss = iv && rdy;
    obs_rdy = in_ready;
    chk({tag, "_rdy"}, {31'b0, in_ready}, {31'b0, rdy});
    va = val_now(r1, wbc, wa, wd);
    vb = val_now(r2, wbc, wa, wd);
    if (wbc) begin
      m_regs[wa] = wd;
      m_busy[wa] = 0;
    end
    if (iss) begin
      m_ov = 1; m_oa = va; m_ob = vb; m_ord = d; m_owe = we;
      if (we && d != 0) m_busy[d] = 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    chk_out(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, tag);
  endtask

  initial begin
    int tries;
    clrn = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
    out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset");
    @(negedge clk);
    clrn = 1;

    // 1: basic read
    step(0, 0, 0, 0, 0, 1, 1, 3, 32'h1234, "t1_wb3");
    step(0, 0, 0, 0, 0, 1, 1, 5, 32'hABCD, "t1_wb5");
    step(1, 3, 5, 1, 0, 1, 0, 0, 0, "t1_iss");
    chk("t1_a", out_a, 32'h1234);
    chk("t1_b", out_b, 32'hABCD);

    // 2: RAW stall released by writeback
    step(1, 0, 0, 7, 1, 1, 0, 0, 0, "t2_a");
    step(1, 7, 0, 2, 0, 1, 0, 0, 0, "t2_b0");
    chk("t2_stall", {31'b0, obs_rdy}, 32'd0);
    tries = 1;
    step(1, 7, 0, 2, 0, 1, 1, 7, 32'h55, "t2_bwb");
    while (!obs_rdy && tries < 4) begin
      tries++;
      step(1, 7, 0, 2, 0, 1, 0, 0, 0, "t2_bw");
    end
    chk("t2_lat", tries, BYP ? 1 : 2);
    chk("t2_a55", out_a, 32'h55);

    // 3: back-pressure holds the buffer
    step(1, 3, 3, 0, 0, 1, 0, 0, 0, "t3_first");
    for (int i = 0; i < 4; i++) begin
      step(1, 5, 3, 6, 0, 0, 0, 0, 0, "t3_hold");
      chk("t3_bp", {31'b0, obs_rdy}, 32'd0);
      chk("t3_a", out_a, 32'h1234);
    end
    step(1, 5, 3, 6, 0, 1, 0, 0, 0, "t3_go");
    chk("t3_new", out_a, 32'hABCD);

    // 4: r0 reads zero, never busy
    step(1, 0, 0, 0, 1, 1, 1, 0, 32'hFFFF, "t4_a");
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, "t4_b");
    chk("t4_nostall", {31'b0, obs_rdy}, 32'd1);
    chk("t4_zero", out_a | out_b, 32'd0);

    // 5: WAW stall, then set-wins on busy[9]
    step(1, 0, 0, 4, 1, 1, 0, 0, 0, "t5_w1");
    step(1, 0, 0, 4, 1, 1, 0, 0, 0, "t5_w2");
    chk("t5_waw", {31'b0, obs_rdy}, 32'd0);
    step(1, 0, 0, 4, 1, 1, 1, 4, 32'h44, "t5_wb");
    if (!obs_rdy) step(1, 0, 0, 4, 1, 1, 0, 0, 0, "t5_w3");
    step(0, 0, 0, 0, 0, 1, 1, 4, 32'h444, "t5_clr4");
    step(1, 0, 0, 9, 1, 1, 1, 9, 32'h99, "t5_set9");
    step(1, 9, 0, 0, 0, 1, 0, 0, 0, "t5_rd9");
    chk("t5_busy9", {31'b0, obs_rdy}, 32'd0);
    step(0, 0, 0, 0, 0, 1, 1, 9, 32'h999, "t5_clr9");

    // 6: async reset mid-stall
    step(1, 0, 0, 7, 1, 1, 0, 0, 0, "t6_a");
    step(1, 7, 0, 0, 0, 0, 0, 0, 0, "t6_stall");
    @(negedge clk);
    in_valid = 0;
    #2 clrn = 0;
    #1;
    model_reset();
    chk("t6_ov", {31'b0, out_valid}, 32'd0);
    chk("t6_oa", out_a, 32'd0);
    @(negedge clk);
    clrn = 1;
    step(1, 7, 0, 0, 0, 1, 0, 0, 0, "t6_after");
    chk("t6_nostall", {31'b0, obs_rdy}, 32'd1);
    chk("t6_zero", out_a, 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit wbe;
      logic [3:0] wa;
      wbe = ($urandom % 10) < 4;
      wa  = 4'($urandom % 16);
      if ($urandom % 2) begin
        for (int k = 0; k < 16; k++)
          if (m_busy[(k + n) % 16]) wa = 4'((k + n) % 16);
      end
      step(($urandom % 4) != 0, 4'($urandom % 8), 4'($urandom % 8),
           4'($urandom % 8), $urandom % 2, ($urandom % 10) < 7,
           wbe, wa, $urandom, "rnd");
    end
    idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
